lcd_pixel_fetch: RTL
====================

// Module: lcd_pixel_fetch
// PURPOSE
//  Upstream feeder of the LCD timing driver. Reads a 640x480 RGB565 frame from a
//  synchronous frame RAM (1-cycle read latency) in raster order. Buffers pixels in a
//  show-ahead FIFO and presents them on a valid/ready port (ram_rd_valid/ram_rd_ready/pixel_data).
//  Restarts the frame on each lcd_vs falling edge. Single clock domain (lcd_clk).
// PARAMETERS
//  IMG_W       640     pixels per active line delivered downstream
//  IMG_H       480     lines per frame
//  ADDR_W      19      frame RAM word-address width (IMG_W*IMG_H <= 2**ADDR_W)
//  FIFO_AW     4       FIFO address width; depth DEPTH = 2**FIFO_AW = 16
// PORTS
//  lcd_clk       in   1       pixel clock, 20 MHz
//  rst_n         in   1       reset, asynchronous, active-low
//  lcd_vs        in   1       vertical sync from driver, active-low
//  mem_rd_en     out  1       frame RAM read strobe
//  mem_rd_addr   out  ADDR_W  frame RAM word address
//  mem_rd_data   in   16      RGB565 data, valid the cycle after mem_rd_en
//  ram_rd_valid  out  1       FIFO non-empty
//  ram_rd_ready  in   1       downstream consumes head pixel this cycle
//  pixel_data    out  16      head pixel; 16'h0000 while FIFO empty
//  frame_err     out  1       sticky: new frame started before previous frame fully delivered
// BEHAVIOUR
//  Reset values
//  - state=IDLE, addr=0, fetch count=0, deliver count=0, FIFO empty, vs_q=1, rd_en_q=0.
//  - All outputs 0 except mem_rd_addr=0.
//  Frame sync
//  - vs_q <= lcd_vs every cycle; vs_fall = vs_q & ~lcd_vs.
//  - On the edge where vs_fall=1, from any state:
//    - FIFO pointers and count cleared; addr=0; both counters=0; state<=FETCH.
//    - rd_en_q is forced to 0, so a read returning that cycle is discarded.
//    - frame_err<=1 if state!=IDLE and deliver count < IMG_W*IMG_H.
//    - frame_err is cleared only by rst_n.
//  FSM IDLE -> FETCH -> DONE -> FETCH
//  - IDLE: no reads; waits for the first vs_fall.
//  - FETCH: mem_rd_en = (count + rd_en_q < DEPTH), combinational, conservative (ignores same-cycle pop).
//    - mem_rd_addr = addr. On each rd_en: addr++, fetch count++.
//    - When fetch count reaches IMG_W*IMG_H-1 with rd_en: state<=DONE.
//  - DONE: mem_rd_en=0. FIFO keeps draining; waits for vs_fall.
//  Read return
//  - rd_en_q <= mem_rd_en.
//  - When rd_en_q=1, mem_rd_data is written at the FIFO tail on that edge.
//  - The FIFO never overflows by construction. An overflow in simulation is an assertion failure.
//  Output port
//  - ram_rd_valid = (count!=0). Pop = ram_rd_valid & ram_rd_ready.
//  - A pop with no valid is ignored.
//  - A simultaneous push and pop leave count unchanged.
//  - pixel_data = head word (combinational read of FIFO memory). No bubble between consecutive pops.
//  - The deliver counter increments on each pop and saturates at IMG_W*IMG_H.
//  Latency
//  - vs_fall edge -> mem_rd_en high the next cycle -> ram_rd_valid high 2 cycles after the vs_fall edge.
//  - Throughput is 1 pixel/cycle sustained.
//  Widths
//  - Counters are ADDR_W bits; addr wraps never (bounded by IMG_W*IMG_H).
//  - FIFO count is FIFO_AW+1 bits; pointers wrap modulo DEPTH.
// TESTING
//  - Reset: hold rst_n=0 -> all outputs 0, no mem_rd_en.
//    Release with lcd_vs=1 for 100 cycles -> still IDLE, no reads.
//  - Fill: vs_fall, ready=0 -> exactly 16 reads, addrs 0..15.
//    Valid 2 cycles after edge; pixel_data=RAM[0]; mem_rd_en stays 0 while full.
//  - Stream: ready=1 continuously after fill, RAM[a]=a[15:0] -> pops deliver 0,1,2,... with no gaps.
//    Reads follow 1/cycle.
//  - Full frame with driver timing (640 pops per line in a 640-cycle window, 480 lines):
//    - exactly 307200 pixels delivered in order; state DONE after addr 307199.
//    - frame_err stays 0 at the next vs_fall.
//  - Mid-frame restart: vs_fall after 1000 pops -> FIFO flushed, in-flight return discarded, frame_err=1.
//    Next pixel delivered is RAM[0].
//  - Simultaneous push/pop at count=15 -> count remains 15, no overflow assertion, order preserved.

Source files
------------

// File: rtl/lcd_pixel_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_pixel_fetch
// Purpose  : Upstream feeder for the LCD timing driver. Walks the frame RAM
//            in raster order, buffers the returned RGB565 words in a
//            show-ahead FIFO and hands them out on a valid/ready port.
//            Every falling edge of lcd_vs restarts the frame from address 0.
// Ports    : lcd_clk      - pixel clock
//            rst_n        - asynchronous active-low reset
//            lcd_vs       - vertical sync from the driver (active-low)
//            mem_rd_en    - frame RAM read strobe
//            mem_rd_addr  - frame RAM word address
//            mem_rd_data  - RAM data, valid the cycle after mem_rd_en
//            ram_rd_valid - FIFO holds at least one pixel
//            ram_rd_ready - downstream takes the head pixel this cycle
//            pixel_data   - head pixel (16'h0000 while the FIFO is empty)
//            frame_err    - sticky: frame restarted before fully delivered
// Revision : 1.0 - initial release
// ============================================================================
module lcd_pixel_fetch #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int ADDR_W  = 19,
  parameter int FIFO_AW = 4
) (
  input  logic              lcd_clk,
  input  logic              rst_n,
  input  logic              lcd_vs,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [15:0]       mem_rd_data,
  output logic              ram_rd_valid,
  input  logic              ram_rd_ready,
  output logic [15:0]       pixel_data,
  output logic              frame_err
);

  localparam int                c_depth    = 2**FIFO_AW;
  localparam logic [ADDR_W-1:0] c_frame_px = ADDR_W'(IMG_W*IMG_H);
  localparam logic [ADDR_W-1:0] c_last_px  = ADDR_W'(IMG_W*IMG_H-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_vs_q;
  logic                 r_rd_en_q;
  logic [ADDR_W-1:0]    r_addr;       // doubles as the fetch count
  logic [ADDR_W-1:0]    r_deliv_cnt;
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [FIFO_AW:0]     r_count;
  logic                 r_frame_err;
  logic [15:0]          r_fifo [c_depth];

  logic                 w_vs_fall;
  logic                 w_push;
  logic                 w_pop;
  logic [FIFO_AW+1:0]   w_level;

  assign w_vs_fall = r_vs_q & ~lcd_vs;

  // Occupancy including the read still in flight; a pop in the same cycle
  // is deliberately ignored so the FIFO can never be overrun.
  assign w_level   = {1'b0, r_count} + {{(FIFO_AW+1){1'b0}}, r_rd_en_q};
  assign mem_rd_en = (r_state == S_FETCH) && (w_level < (FIFO_AW+2)'(c_depth));

  assign ram_rd_valid = (r_count != '0);
  assign pixel_data   = ram_rd_valid ? r_fifo[r_rd_ptr] : 16'h0000;
  assign mem_rd_addr  = r_addr;
  assign frame_err    = r_frame_err;

  // A frame restart flushes the FIFO, so neither the returning read nor a
  // pop on that edge may touch the FIFO state.
  assign w_push = r_rd_en_q & ~w_vs_fall;
  assign w_pop  = ram_rd_valid & ram_rd_ready & ~w_vs_fall;

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_vs_q      <= 1'b1;
      r_rd_en_q   <= 1'b0;
      r_addr      <= '0;
      r_deliv_cnt <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_vs_q <= lcd_vs;
      if (w_vs_fall) begin
        if ((r_state != S_IDLE) && (r_deliv_cnt < c_frame_px))
          r_frame_err <= 1'b1;
        r_state     <= S_FETCH;
        r_rd_en_q   <= 1'b0;
        r_addr      <= '0;
        r_deliv_cnt <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
      end else begin
        r_rd_en_q <= mem_rd_en;

        case (r_state)
          S_FETCH: begin
            if (mem_rd_en) begin
              r_addr <= r_addr + ADDR_W'(1);
              if (r_addr == c_last_px)
                r_state <= S_DONE;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase

        if (w_push)
          r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
          if (r_deliv_cnt != c_frame_px)
            r_deliv_cnt <= r_deliv_cnt + ADDR_W'(1);
        end

        if (w_push && !w_pop)
          r_count <= r_count + (FIFO_AW+1)'(1);
        else if (!w_push && w_pop)
          r_count <= r_count - (FIFO_AW+1)'(1);

        a_no_overflow: assert (!(w_push && !w_pop && (r_count == (FIFO_AW+1)'(c_depth))));
      end
    end
  end

  // Storage kept free of reset so it maps onto a plain RAM.
  always_ff @(posedge lcd_clk) begin
    if (w_push)
      r_fifo[r_wr_ptr] <= mem_rd_data;
  end

endmodule
`default_nettype wire
